// File: rtl/amo_sequencer.sv
// amo_sequencer: runs RV32A LR.W / SC.W / AMO*.W from the MEM stage as a
// read-modify-write on the data port, owns the LR/SC reservation and
// freezes the pipeline while a transaction is in flight.
module amo_sequencer #(
    parameter int XLEN     = 32,
    parameter int RSV_GRAN = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            amo_valid,
    input  logic [4:0]      amo_funct5,
    input  logic [XLEN-1:0] amo_addr,
    input  logic [XLEN-1:0] amo_rs2,
    input  logic            trap,
    input  logic            snoop_st_valid,
    input  logic [XLEN-1:0] snoop_st_addr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            atomic_unit_stall,
    output logic            amo_done,
    output logic [XLEN-1:0] amo_result,
    output logic            amo_fault
);
    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [4:0]             funct5_r;
    logic [XLEN-1:2]        addr_r;
    logic [XLEN-1:0]        rs2_r;
    logic [XLEN-1:0]        old_r;
    logic [XLEN-1:0]        result_r;
    logic                   fault_r;
    logic                   rsv_valid_r;
    logic [XLEN-1:RSV_GRAN] rsv_addr_r;

    logic accept_s;
    logic bad_s;
    logic rsv_hit_s;
    logic snoop_hit_s;
    logic is_lr_s;
    logic is_sc_s;
    logic rsv_set_s;
    logic rsv_clr_s;
    logic unused_s;

    function automatic logic op_supported(input logic [4:0] f);
        case (f)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: op_supported = 1'b1;
            default:                          op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] amo_apply(input logic [4:0]      f,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] rs2);
        case (f)
            F5_ADD:  amo_apply = old + rs2;
            F5_XOR:  amo_apply = old ^ rs2;
            F5_OR:   amo_apply = old | rs2;
            F5_AND:  amo_apply = old & rs2;
            F5_MIN:  amo_apply = ($signed(old) < $signed(rs2)) ? old : rs2;
            F5_MAX:  amo_apply = ($signed(old) > $signed(rs2)) ? old : rs2;
            F5_MINU: amo_apply = (old < rs2) ? old : rs2;
            F5_MAXU: amo_apply = (old > rs2) ? old : rs2;
            // SWAP and a successful SC both store rs2 unchanged
            default: amo_apply = rs2;
        endcase
    endfunction

    // trap in IDLE blocks acceptance; faults are decided on the incoming operands
    assign accept_s    = (state_r == ST_IDLE) && amo_valid && !trap;
    assign bad_s       = (amo_addr[1:0] != 2'b00) || !op_supported(amo_funct5);
    assign rsv_hit_s   = rsv_valid_r && (amo_addr[XLEN-1:RSV_GRAN] == rsv_addr_r);
    assign snoop_hit_s = snoop_st_valid && rsv_valid_r &&
                         (snoop_st_addr[XLEN-1:RSV_GRAN] == rsv_addr_r);
    assign is_lr_s     = (funct5_r == F5_LR);
    assign is_sc_s     = (funct5_r == F5_SC);
    assign rsv_set_s   = (state_r == ST_READ) && mem_ack && is_lr_s;
    assign rsv_clr_s   = trap || snoop_hit_s || ((state_r == ST_DONE) && is_sc_s);
    assign unused_s    = ^snoop_st_addr[RSV_GRAN-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (bad_s) begin
                    state_s = ST_DONE;
                end else if (amo_funct5 == F5_SC) begin
                    state_s = rsv_hit_s ? ST_WRITE : ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_READ: begin
                // an ack coinciding with trap still ends the request; the op is abandoned
                if (trap) begin
                    state_s = ST_IDLE;
                end else if (mem_ack) begin
                    state_s = is_lr_s ? ST_DONE : ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                // a write in flight is never torn, trap or not
                if (mem_ack) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand capture at acceptance, early results, and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            funct5_r <= 5'b00000;
            addr_r   <= {(XLEN-2){1'b0}};
            rs2_r    <= {XLEN{1'b0}};
            old_r    <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            fault_r  <= 1'b0;
        end else if (accept_s) begin
            funct5_r <= amo_funct5;
            addr_r   <= amo_addr[XLEN-1:2];
            rs2_r    <= amo_rs2;
            fault_r  <= bad_s;
            // SC failure reports 1; fault and SC success report 0
            result_r <= (!bad_s && (amo_funct5 == F5_SC) && !rsv_hit_s) ?
                        {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
        end else if ((state_r == ST_READ) && mem_ack) begin
            old_r    <= mem_rdata;
            result_r <= mem_rdata;
        end
    end

    // Reservation: clear has priority over set
    always_ff @(posedge clk) begin
        if (reset) begin
            rsv_valid_r <= 1'b0;
            rsv_addr_r  <= {(XLEN-RSV_GRAN){1'b0}};
        end else if (rsv_clr_s) begin
            rsv_valid_r <= 1'b0;
        end else if (rsv_set_s) begin
            rsv_valid_r <= 1'b1;
            rsv_addr_r  <= {addr_r, 2'b00} >> RSV_GRAN;
        end
    end

    // Bus and result outputs are pure decodes of registered state
    assign mem_req           = (state_r == ST_READ) || (state_r == ST_WRITE);
    assign mem_we            = (state_r == ST_WRITE);
    assign mem_addr          = mem_req ? {addr_r, 2'b00} : {XLEN{1'b0}};
    assign mem_wdata         = mem_we ? amo_apply(funct5_r, old_r, rs2_r) : {XLEN{1'b0}};
    assign amo_done          = (state_r == ST_DONE);
    assign amo_result        = amo_done ? result_r : {XLEN{1'b0}};
    assign amo_fault         = amo_done && fault_r;
    assign atomic_unit_stall = ((state_r == ST_IDLE) && amo_valid) || mem_req;

endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer: directed and randomized checks of amo_sequencer against
// a transaction-level model of memory and the LR/SC reservation.
module tb_amo_sequencer;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic        clk = 1'b0;
    logic        reset, amo_valid, trap, snoop_st_valid, mem_ack;
    logic [4:0]  amo_funct5;
    logic [31:0] amo_addr, amo_rs2, snoop_st_addr, mem_rdata;
    logic        mem_req, mem_we, atomic_unit_stall, amo_done, amo_fault;
    logic [31:0] mem_addr, mem_wdata, amo_result;

    int checks = 0;
    int errors = 0;

    // memory behind the port (phys) and the expected memory (mdl)
    logic [31:0] phys [logic [31:0]];
    logic [31:0] mdl  [logic [31:0]];
    bit          rsv_v = 1'b0;
    logic [31:0] rsv_a = 32'h0;

    int ack_delay = 0, wait_cnt = 0, req_cycles = 0, wr_count = 0;
    int unstable = 0, bad_align = 0, done_count = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;

    always #5 clk = ~clk;

    amo_sequencer dut (
        .clk(clk), .reset(reset), .amo_valid(amo_valid), .amo_funct5(amo_funct5),
        .amo_addr(amo_addr), .amo_rs2(amo_rs2), .trap(trap),
        .snoop_st_valid(snoop_st_valid), .snoop_st_addr(snoop_st_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .atomic_unit_stall(atomic_unit_stall),
        .amo_done(amo_done), .amo_result(amo_result), .amo_fault(amo_fault)
    );

    function automatic logic [31:0] wkey(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(wkey(a)) ? phys[wkey(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(wkey(a)) ? mdl[wkey(a)] : 32'h0;
    endfunction

    // memory responder: acks after ack_delay wait cycles, watches bus rules
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (amo_done) done_count++;
            if (mem_req) begin
                req_cycles++;
                if (mem_addr[1:0] != 2'b00) bad_align++;
                if (prev_req && !prev_ack &&
                    (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
                    unstable++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        phys[mem_addr] = mem_wdata;
                        wr_count++;
                        mem_rdata = 32'h0;
                    end else begin
                        mem_rdata = phys_rd(mem_addr);
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                    mem_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt = 0;
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
            prev_addr = mem_addr; prev_wdata = mem_wdata;
        end
    end

    function automatic bit op_ok(input logic [4:0] f);
        return f inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                         F_MIN, F_MAX, F_MINU, F_MAXU};
    endfunction

    function automatic logic [31:0] op_value(input logic [4:0] f, input logic [31:0] old,
                                             input logic [31:0] rs2);
        int so, sr;
        so = old; sr = rs2;
        case (f)
            F_ADD:  return old + rs2;
            F_XOR:  return old ^ rs2;
            F_OR:   return old | rs2;
            F_AND:  return old & rs2;
            F_MIN:  return (so <= sr) ? old : rs2;
            F_MAX:  return (so >= sr) ? old : rs2;
            F_MINU: return (old <= rs2) ? old : rs2;
            F_MAXU: return (old >= rs2) ? old : rs2;
            default: return rs2;
        endcase
    endfunction

    // expected outcome of one transaction; updates model memory and reservation
    task automatic model_txn(input logic [4:0] f, input logic [31:0] a, input logic [31:0] rs2,
                             input int d, output logic [31:0] res, output bit flt, output int cyc);
        logic [31:0] old;
        flt = 1'b0;
        if (a[1:0] != 2'b00 || !op_ok(f)) begin
            res = 32'h0; flt = 1'b1; cyc = 1;
            if (f == F_SC) rsv_v = 1'b0;
        end else if (f == F_SC) begin
            if (rsv_v && (a >> 2) == (rsv_a >> 2)) begin
                mdl[wkey(a)] = rs2; res = 32'h0; cyc = 2 + d;
            end else begin
                res = 32'h1; cyc = 1;
            end
            rsv_v = 1'b0;
        end else if (f == F_LR) begin
            res = mdl_rd(a); rsv_v = 1'b1; rsv_a = a; cyc = 2 + d;
        end else begin
            old = mdl_rd(a);
            mdl[wkey(a)] = op_value(f, old, rs2);
            res = old; cyc = 3 + 2 * d;
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        phys[wkey(a)] = v;
        mdl[wkey(a)] = v;
    endtask

    // drives one instruction; cycle 0 is the acceptance cycle
    task automatic run_amo(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] rs2,
                           input int d, input int trap_at, input int max_cyc,
                           output bit done_seen, output logic [31:0] res, output bit flt,
                           output int done_cyc, output int stall_err);
        done_seen = 1'b0; res = 32'h0; flt = 1'b0; done_cyc = -1; stall_err = 0;
        @(negedge clk);
        ack_delay = d; amo_valid = 1'b1; amo_funct5 = f5; amo_addr = a; amo_rs2 = rs2;
        for (int c = 0; c < max_cyc; c++) begin
            trap = (c == trap_at);
            #1;
            if (amo_done) begin
                done_seen = 1'b1; res = amo_result; flt = amo_fault; done_cyc = c;
                if (trap_at < 0 && atomic_unit_stall) stall_err++;
                break;
            end
            if (trap_at < 0 && !atomic_unit_stall) stall_err++;
            @(negedge clk);
            if (trap_at >= 0 && c >= trap_at) amo_valid = 1'b0;
        end
        amo_valid = 1'b0;
        trap = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a);
        @(negedge clk);
        snoop_st_valid = 1'b1; snoop_st_addr = a;
        if (rsv_v && (a >> 2) == (rsv_a >> 2)) rsv_v = 1'b0;
        @(negedge clk);
        snoop_st_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; amo_valid = 1'b0; trap = 1'b0; snoop_st_valid = 1'b0;
        amo_funct5 = 5'b00000; amo_addr = 32'h0; amo_rs2 = 32'h0; snoop_st_addr = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, amo_done, amo_fault, atomic_unit_stall} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/we/done/fault/stall=%b want 00000",
                     {mem_req, mem_we, amo_done, amo_fault, atomic_unit_stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, amo_result} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h result=%h want 0",
                     mem_addr, mem_wdata, amo_result);
        end
        reset = 1'b0;
        rsv_v = 1'b0;
    endtask

    task automatic test_amoadd();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec;
        set_word(32'h100, 32'h7FFF_FFFF);
        model_txn(F_ADD, 32'h100, 32'h1, 0, er, ef, ec);
        run_amo(F_ADD, 32'h100, 32'h1, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'h7FFF_FFFF || fl) begin
            errors++;
            $display("FAIL amoadd_result: got done=%0d result=%h fault=%0d want 1 7fffffff 0", ds, r, fl);
        end
        checks++;
        if (dc != 3 || se != 0) begin
            errors++;
            $display("FAIL amoadd_timing: got done_cycle=%0d stall_err=%0d want 3 0", dc, se);
        end
        checks++;
        if (phys_rd(32'h100) !== 32'h8000_0000) begin
            errors++;
            $display("FAIL amoadd_mem: got %h want 80000000", phys_rd(32'h100));
        end
    endtask

    task automatic test_min_minu();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec;
        set_word(32'h108, 32'hFFFF_FFFF);
        set_word(32'h10C, 32'hFFFF_FFFF);
        model_txn(F_MIN, 32'h108, 32'h1, 0, er, ef, ec);
        run_amo(F_MIN, 32'h108, 32'h1, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'hFFFF_FFFF || phys_rd(32'h108) !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL amomin: got done=%0d result=%h mem=%h want 1 ffffffff ffffffff",
                     ds, r, phys_rd(32'h108));
        end
        model_txn(F_MINU, 32'h10C, 32'h1, 0, er, ef, ec);
        run_amo(F_MINU, 32'h10C, 32'h1, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'hFFFF_FFFF || phys_rd(32'h10C) !== 32'h0000_0001) begin
            errors++;
            $display("FAIL amominu: got done=%0d result=%h mem=%h want 1 ffffffff 00000001",
                     ds, r, phys_rd(32'h10C));
        end
    endtask

    task automatic test_lr_sc();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec, rq;
        set_word(32'h200, 32'h1234_5678);
        model_txn(F_LR, 32'h200, 32'h0, 0, er, ef, ec);
        run_amo(F_LR, 32'h200, 32'h0, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'h1234_5678 || dc != 2) begin
            errors++;
            $display("FAIL lr: got done=%0d result=%h cycle=%0d want 1 12345678 2", ds, r, dc);
        end
        model_txn(F_SC, 32'h200, 32'hAB, 0, er, ef, ec);
        run_amo(F_SC, 32'h200, 32'hAB, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'h0 || dc != 2 || phys_rd(32'h200) !== 32'hAB) begin
            errors++;
            $display("FAIL sc_ok: got done=%0d result=%h cycle=%0d mem=%h want 1 0 2 ab",
                     ds, r, dc, phys_rd(32'h200));
        end
        model_txn(F_LR, 32'h200, 32'h0, 0, er, ef, ec);
        run_amo(F_LR, 32'h200, 32'h0, 0, -1, 20, ds, r, fl, dc, se);
        snoop(32'h202);
        rq = req_cycles;
        model_txn(F_SC, 32'h200, 32'hCD, 0, er, ef, ec);
        run_amo(F_SC, 32'h200, 32'hCD, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'h1 || dc != 1 || req_cycles != rq || phys_rd(32'h200) !== 32'hAB) begin
            errors++;
            $display("FAIL sc_snooped: got done=%0d result=%h cycle=%0d reqs=%0d mem=%h want 1 1 1 0 ab",
                     ds, r, dc, req_cycles - rq, phys_rd(32'h200));
        end
    endtask

    task automatic test_fault();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec, rq;
        rq = req_cycles;
        model_txn(F_ADD, 32'h103, 32'h5, 0, er, ef, ec);
        run_amo(F_ADD, 32'h103, 32'h5, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || !fl || r !== 32'h0 || dc != 1 || req_cycles != rq) begin
            errors++;
            $display("FAIL misaligned: got done=%0d fault=%0d result=%h cycle=%0d reqs=%0d want 1 1 0 1 0",
                     ds, fl, r, dc, req_cycles - rq);
        end
        model_txn(5'b00101, 32'h100, 32'h5, 0, er, ef, ec);
        run_amo(5'b00101, 32'h100, 32'h5, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || !fl || dc != 1 || req_cycles != rq) begin
            errors++;
            $display("FAIL unsupported: got done=%0d fault=%0d cycle=%0d reqs=%0d want 1 1 1 0",
                     ds, fl, dc, req_cycles - rq);
        end
    endtask

    task automatic test_wait_and_trap();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec, us, wr, rq, dn;
        set_word(32'h110, 32'd10);
        us = unstable;
        model_txn(F_ADD, 32'h110, 32'd5, 3, er, ef, ec);
        run_amo(F_ADD, 32'h110, 32'd5, 3, -1, 30, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'd10 || dc != 9 || se != 0 || unstable != us || phys_rd(32'h110) !== 32'd15) begin
            errors++;
            $display("FAIL wait3: got done=%0d result=%h cycle=%0d stall_err=%0d unstable=%0d mem=%h want 1 a 9 0 0 f",
                     ds, r, dc, se, unstable - us, phys_rd(32'h110));
        end
        set_word(32'h114, 32'h20);
        wr = wr_count;
        run_amo(F_ADD, 32'h114, 32'h1, 3, 2, 12, ds, r, fl, dc, se);
        rsv_v = 1'b0;
        checks++;
        if (ds || wr_count != wr || phys_rd(32'h114) !== 32'h20 || mem_req) begin
            errors++;
            $display("FAIL trap_read: got done=%0d writes=%0d mem=%h req=%0d want 0 0 20 0",
                     ds, wr_count - wr, phys_rd(32'h114), mem_req);
        end
        set_word(32'h118, 32'h30);
        model_txn(F_ADD, 32'h118, 32'h2, 1, er, ef, ec);
        run_amo(F_ADD, 32'h118, 32'h2, 1, 3, 20, ds, r, fl, dc, se);
        rsv_v = 1'b0;
        checks++;
        if (!ds || r !== er || dc != ec || phys_rd(32'h118) !== 32'h32) begin
            errors++;
            $display("FAIL trap_write: got done=%0d result=%h cycle=%0d mem=%h want 1 %h %0d 32",
                     ds, r, dc, phys_rd(32'h118), er, ec);
        end
        rq = req_cycles; dn = done_count;
        @(negedge clk);
        amo_valid = 1'b1; trap = 1'b1; amo_funct5 = F_ADD; amo_addr = 32'h118;
        @(negedge clk);
        amo_valid = 1'b0; trap = 1'b0;
        rsv_v = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (req_cycles != rq || done_count != dn) begin
            errors++;
            $display("FAIL trap_idle: got reqs=%0d dones=%0d want 0 0", req_cycles - rq, done_count - dn);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec, wr;
        set_word(32'h300, 32'h11);
        model_txn(F_LR, 32'h300, 32'h0, 0, er, ef, ec);
        run_amo(F_LR, 32'h300, 32'h0, 0, -1, 20, ds, r, fl, dc, se);
        wr = wr_count;
        @(negedge clk);
        ack_delay = 0; amo_valid = 1'b1; amo_funct5 = F_SWAP; amo_addr = 32'h300; amo_rs2 = 32'h55;
        @(negedge clk); #1;
        ack_delay = 50;
        @(negedge clk); #1;
        checks++;
        if (!(mem_req && mem_we)) begin
            errors++;
            $display("FAIL rst_write_entry: got req=%0d we=%0d want 1 1", mem_req, mem_we);
        end
        reset = 1'b1; amo_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (mem_req || amo_done || atomic_unit_stall || wr_count != wr || phys_rd(32'h300) !== 32'h11) begin
            errors++;
            $display("FAIL rst_write: got req=%0d done=%0d stall=%0d writes=%0d mem=%h want 0 0 0 0 11",
                     mem_req, amo_done, atomic_unit_stall, wr_count - wr, phys_rd(32'h300));
        end
        reset = 1'b0; ack_delay = 0; rsv_v = 1'b0;
        model_txn(F_SC, 32'h300, 32'h99, 0, er, ef, ec);
        run_amo(F_SC, 32'h300, 32'h99, 0, -1, 20, ds, r, fl, dc, se);
        checks++;
        if (!ds || r !== 32'h1 || phys_rd(32'h300) !== 32'h11) begin
            errors++;
            $display("FAIL rst_rsv: got done=%0d sc_result=%h mem=%h want 1 1 11", ds, r, phys_rd(32'h300));
        end
    endtask

    task automatic test_back_to_back();
        bit ds, fl, ef; logic [31:0] r, er; int dc, se, ec;
        logic [4:0] seq [4];
        seq[0] = F_ADD; seq[1] = F_XOR; seq[2] = F_LR; seq[3] = F_SC;
        set_word(32'h204, 32'h0F0F_0000);
        for (int k = 0; k < 4; k++) begin
            model_txn(seq[k], 32'h204, 32'h0000_F00F + k, 0, er, ef, ec);
            run_amo(seq[k], 32'h204, 32'h0000_F00F + k, 0, -1, 20, ds, r, fl, dc, se);
            checks++;
            if (!ds || r !== er || fl !== ef || dc != ec || se != 0 || phys_rd(32'h204) !== mdl_rd(32'h204)) begin
                errors++;
                $display("FAIL b2b[%0d]: got done=%0d result=%h cycle=%0d stall_err=%0d mem=%h want 1 %h %0d 0 %h",
                         k, ds, r, dc, se, phys_rd(32'h204), er, ec, mdl_rd(32'h204));
            end
        end
    endtask

    function automatic logic [4:0] pick_op(input int k);
        case (k)
            0: return F_ADD;   1: return F_SWAP;  2: return F_XOR;   3: return F_AND;
            4: return F_OR;    5: return F_MIN;   6: return F_MAX;   7: return F_MINU;
            8: return F_MAXU;  9, 10: return F_LR; 11, 12: return F_SC;
            13: return 5'b00101;
            default: return 5'b11111;
        endcase
    endfunction

    task automatic test_random();
        bit ds, fl, ef; logic [31:0] r, er, a, rs2, last_lr; int dc, se, ec, d, sel;
        logic [4:0] f5;
        logic [31:0] bases [4];
        bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h200; bases[3] = 32'h204;
        for (int k = 0; k < 4; k++) set_word(bases[k], $urandom);
        last_lr = 32'h100;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                snoop(bases[$urandom_range(0, 3)] + $urandom_range(0, 3));
            end else if (sel == 1) begin
                @(negedge clk); trap = 1'b1;
                @(negedge clk); trap = 1'b0;
                rsv_v = 1'b0;
            end
            f5 = pick_op($urandom_range(0, 14));
            a = bases[$urandom_range(0, 3)];
            if (f5 == F_SC && $urandom_range(0, 1) == 1) a = last_lr;
            if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
            if (f5 == F_LR) last_lr = a;
            rs2 = $urandom;
            if ($urandom_range(0, 3) == 0) rs2 = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            d = $urandom_range(0, 2);
            model_txn(f5, a, rs2, d, er, ef, ec);
            run_amo(f5, a, rs2, d, -1, 20, ds, r, fl, dc, se);
            checks++;
            if (!ds || r !== er || fl !== ef || dc != ec || se != 0 || phys_rd(a) !== mdl_rd(a)) begin
                errors++;
                $display("FAIL rand[%0d] f5=%b a=%h: got done=%0d result=%h fault=%0d cycle=%0d stall_err=%0d mem=%h want 1 %h %0d %0d 0 %h",
                         i, f5, a, ds, r, fl, dc, se, phys_rd(a), er, ef, ec, mdl_rd(a));
            end
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (bad_align != 0 || unstable != 0) begin
            errors++;
            $display("FAIL bus_rules: got misaligned_reqs=%0d unstable_cycles=%0d want 0 0", bad_align, unstable);
        end
    endtask

    initial begin
        test_reset();
        test_amoadd();
        test_min_minu();
        test_lr_sc();
        test_fault();
        test_wait_and_trap();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        test_bus_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
